des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 75 +++++++
 rtl/des_pc2.sv | 18 +
 rtl/des_key_schedule.sv | 113 +++++++++++
 tb/tb_des_key_schedule.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
//==== des_pkg -- shared DES tables, permutation helpers and schedule FSM type ====
//==== rev 1.0 ====
`default_nettype none

package des_pkg;

  localparam int DES_MAX_ROUNDS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Tables hold 1-based DES bit numbers; bit 1 is the MSB of each vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return cd;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // True when any key byte fails DES odd parity.
  function automatic logic key_parity_bad(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2.sv
//==== des_pc2 -- DES permuted choice 2: 56-bit C||D to 48-bit round key ====
//==== rev 1.0 ====
`default_nettype none

module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] key
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign key[47-i] = cd[6'(56 - PC2[i])];
  end

endmodule

`default_nettype wire

// File: rtl/des_key_schedule.sv
//==== des_key_schedule -- DES round-key generator with ready/valid output ====
//==== rev 1.0 -- optional key parity flag: DES_KEY_PARITY_CHECK_EN ====
`default_nettype none

module des_key_schedule
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        key_par_err
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t      state;
  logic [27:0] c_half;
  logic [27:0] d_half;
  logic        dec_mode;
  logic [55:0] key_pc1;
  logic [47:0] pc2_key;
  logic [1:0]  step;
  logic        handshake;
  logic        last_key;

  assign key_pc1   = pc1_perm(key_in);
  assign handshake = rk_valid & rk_ready;
  assign last_key  = (round_idx == LAST_IDX);

  // Encrypt walks forward through SHIFT, decrypt walks it backwards with right rotations.
  assign step = dec_mode ? SHIFT[4'd15 - round_idx] : SHIFT[round_idx + 4'd1];

  des_pc2 u_pc2 (
    .cd  ({c_half, d_half}),
    .key (pc2_key)
  );

  assign round_key = rk_valid ? pc2_key : 48'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      round_idx <= 4'd0;
      c_half    <= 28'd0;
      d_half    <= 28'd0;
      dec_mode  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            round_idx <= 4'd0;
            dec_mode  <= decrypt;
            // K1 needs one left shift; K16 is the unrotated PC-1 value.
            c_half    <= decrypt ? key_pc1[55:28] : rotl28(key_pc1[55:28], 2'd1);
            d_half    <= decrypt ? key_pc1[27:0]  : rotl28(key_pc1[27:0], 2'd1);
          end
        end
        RUN: begin
          if (handshake) begin
            if (last_key) begin
              state     <= IDLE;
              busy      <= 1'b0;
              rk_valid  <= 1'b0;
              done      <= 1'b1;
              round_idx <= 4'd0;
            end else begin
              round_idx <= round_idx + 4'd1;
              c_half    <= dec_mode ? rotr28(c_half, step) : rotl28(c_half, step);
              d_half    <= dec_mode ? rotr28(d_half, step) : rotl28(d_half, step);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (state == IDLE && start) begin
      par_err <= key_parity_bad(key_in);
    end
  end

  assign key_par_err = par_err;
`else
  assign key_par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
//==== tb_des_key_schedule -- scoreboard bench for des_key_schedule ====
//==== rev 1.0 ====
`default_nettype none

module tb_des_key_schedule;

  localparam int R = 16;
  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key_in = 64'h0;
  logic        decrypt = 1'b0;
  logic        busy, rk_valid, done, key_par_err;
  logic        rk_ready = 1'b0;
  logic [47:0] round_key;
  logic [3:0]  round_idx;

  logic        start4 = 1'b0;
  logic [63:0] key4 = 64'h0;
  logic        decrypt4 = 1'b0;
  logic        ready4 = 1'b1;
  logic        busy4, rk_valid4, done4, par4;
  logic [47:0] round_key4;
  logic [3:0]  round_idx4;

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .decrypt(decrypt),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .round_idx(round_idx), .done(done), .key_par_err(key_par_err)
  );

  des_key_schedule #(.ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4), .decrypt(decrypt4),
    .busy(busy4), .rk_valid(rk_valid4), .rk_ready(ready4), .round_key(round_key4),
    .round_idx(round_idx4), .done(done4), .key_par_err(par4)
  );

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
    logic        last;
    logic        par;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] log_q[$];
  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;

  // Reference: DES subkey n (1..16) from the standard tables and cumulative shifts.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] out;
    int tot;
    tot = 0;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1_T[i]];
      d[27-i] = k[64-PC1_T[28+i]];
    end
    for (int j = 0; j < n; j++) tot += SH[j];
    tot = tot % 28;
    c = (c << tot) | (c >> (28 - tot));
    d = (d << tot) | (d >> (28 - tot));
    cd = {c, d};
    for (int i = 0; i < 48; i++) out[47-i] = cd[56-PC2_T[i]];
    return out;
  endfunction

  function automatic logic par_bad(input logic [63:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ($countones(k[8*i +: 8]) % 2 == 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks done/hold rules.
  logic        prev_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_key = 48'h0;
  logic [3:0]  prev_idx = 4'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_last = 1'b0;
      prev_stall = 1'b0;
      hs_cnt = 0;
    end else begin
      check("done_pulse", 64'(done), 64'(prev_last));
      if (prev_last) check("idle_after_done", {62'd0, busy, rk_valid}, 64'd0);
      prev_last = 1'b0;
      if (!rk_valid) check("key_zero_when_invalid", 64'(round_key), 64'd0);
      if (rk_valid && prev_stall) begin
        check("hold_key", 64'(round_key), 64'(prev_key));
        check("hold_idx", 64'(round_idx), 64'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key: got %h want none", round_key);
        end else begin
          e = sb.pop_front();
          check("round_key", 64'(round_key), 64'(e.key));
          check("round_idx", 64'(round_idx), 64'(e.idx));
          check("key_par_err", 64'(key_par_err), 64'(e.par));
          log_q.push_back(round_key);
          prev_last = e.last;
          hs_cnt = e.last ? 0 : hs_cnt + 1;
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_key = round_key;
      prev_idx = round_idx;
    end
  end

  // Issue one run; called at posedge+#1 with the DUT idle.
  task automatic run(input logic [63:0] k, input logic dec, input bit full_ready,
                     input int stall_at, input int rst_at, input bit glitch);
    exp_t e;
    logic exp_par;
    int   stall_left;
    bit   stalled;
    bit   finished;
`ifdef DES_KEY_PARITY_CHECK_EN
    exp_par = par_bad(k);
`else
    exp_par = 1'b0;
`endif
    log_q.delete();
    for (int m = 0; m < R; m++) begin
      e.key  = ref_key(k, dec ? 16 - m : m + 1);
      e.idx  = 4'(m);
      e.last = (m == R - 1);
      e.par  = exp_par;
      sb.push_back(e);
    end
    start = 1'b1;
    key_in = k;
    decrypt = dec;
    rk_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = 1'($urandom);
    check("busy_valid_after_start", {62'd0, busy, rk_valid}, 64'd3);
    stalled = 0;
    stall_left = 0;
    finished = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (rst_at >= 0 && hs_cnt == rst_at) begin
        rst_n = 1'b0;
        start = 1'b1;
        rk_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        sb.delete();
        check("after_reset_flags", {59'd0, busy, rk_valid, done, key_par_err, 1'b0}, 64'd0);
        check("after_reset_key", 64'(round_key), 64'd0);
        return;
      end
      if (stall_at >= 0 && !stalled && hs_cnt == stall_at) begin
        stalled = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = full_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      start = glitch ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (glitch) key_in = {$urandom, $urandom};
      @(posedge clk); #1;
      if (done) finished = 1;
    end
    start = 1'b0;
    rk_ready = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got no done want done");
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n4;
    int dones4;
    logic [63:0] rk;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {58'd0, busy, rk_valid, done, key_par_err, busy4, rk_valid4}, 64'd0);
    check("reset_key", 64'(round_key), 64'd0);
    check("reset_idx", 64'(round_idx), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(KAT, 1'b0, 1, -1, -1, 0);
    check("kat_enc_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      check("kat_enc_k1", 64'(log_q[0]), 64'h1B02EFFC7072);
      check("kat_enc_k2", 64'(log_q[1]), 64'h79AED9DBC9E5);
      check("kat_enc_k16", 64'(log_q[15]), 64'hCB3D8B0E17F5);
    end

    run(KAT, 1'b1, 1, -1, -1, 0);
    check("kat_dec_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      check("kat_dec_first", 64'(log_q[0]), 64'hCB3D8B0E17F5);
      check("kat_dec_last", 64'(log_q[15]), 64'h1B02EFFC7072);
    end

    run(KAT, 1'b0, 1, 3, -1, 0);
    check("stall_count", 64'(log_q.size()), 64'd16);

    run(KAT, 1'b0, 1, -1, 7, 0);
    run(KAT, 1'b0, 1, -1, -1, 0);
    if (log_q.size() > 0) check("post_reset_k1", 64'(log_q[0]), 64'h1B02EFFC7072);

    run(64'h133457799BBCDFF0, 1'b0, 0, -1, -1, 1);
    run(KAT, 1'b0, 0, -1, -1, 1);

    for (int t = 0; t < 6; t++) begin
      run({$urandom, $urandom}, 1'($urandom), 0, $urandom_range(0, 15), -1, 1);
    end

    // ROUNDS=4 instance: K1..K4 only, mid-run start ignored.
    key4 = KAT;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    key4 = {$urandom, $urandom};
    n4 = 0;
    dones4 = 0;
    for (int c = 0; c < 14; c++) begin
      if (rk_valid4) begin
        rk = 64'(ref_key(KAT, n4 + 1));
        check("r4_key", 64'(round_key4), rk);
        check("r4_idx", 64'(round_idx4), 64'(n4));
        n4++;
      end
      if (done4) dones4++;
      start4 = (c == 1);
      @(posedge clk); #1;
    end
    check("r4_key_count", 64'(n4), 64'd4);
    check("r4_done_count", 64'(dones4), 64'd1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
